// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller that owns the HI/LO pair.
//
// It accepts mult/multu/div/divu issued from EX. It holds busy while it
// iterates and writes HI/LO on completion. It asks the hazard unit to stall
// whenever the ID-stage instruction touches HI/LO before the result is final.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      single-cycle issue pulse (op, a, b sampled with it)
//   op[1:0]    00 mult, 01 multu, 10 div, 11 divu
//   a, b       rs / rt operands (dividend/multiplicand, divisor/multiplier)
//   hilo_we    bit1 = mthi, bit0 = mtlo; write data on wd (IDLE only)
//   use_hilo   ID-stage instruction reads/writes HI/LO or uses the unit
//   busy       operation in progress
//   stall_req  freeze PC/IF-ID, bubble ID-EX
//   hi, lo     HI/LO registers
//
// Build option: define MDU_DIV_EN to include the restoring divider. Without
// it, div/divu take one busy cycle and leave HI/LO untouched, like a divide
// by zero.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes accepted
// MUL   | product settling, counter MULT_CYCLES-1 down to 0
// DIV   | one restoring quotient bit per cycle, counter 31 down to 0
// FIX   | apply signs and write HI/LO (skipped write on divide by zero)

module mdu_ctrl #(
  parameter int MULT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] wd,
  input  logic        use_hilo,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd3
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // MUL: raw operands. DIV: opa is the dividend/quotient shift register,
  // opb the divisor magnitude.
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] ext_a, ext_b, prod;

`ifdef MDU_DIV_EN
  logic [31:0] rem_q, rem_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [32:0] shifted, diff;
  logic [31:0] a_mag, b_mag;

  assign shifted = {rem_q, opa_q[31]};
  assign diff    = shifted - {1'b0, opb_q};
  assign a_mag   = (~op[0] & a[31]) ? (~a + 32'd1) : a;
  assign b_mag   = (~op[0] & b[31]) ? (~b + 32'd1) : b;
`endif

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both mult and multu.
  assign ext_a = {{32{sgn_q & opa_q[31]}}, opa_q};
  assign ext_b = {{32{sgn_q & opb_q[31]}}, opb_q};
  assign prod  = ext_a * ext_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV_EN
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A write in the same cycle as start lands now; the result later
        // overwrites it.
        if (hilo_we[1]) hi_d = wd;
        if (hilo_we[0]) lo_d = wd;
        if (start) begin
          sgn_d = ~op[0];
          if (!op[1]) begin
            opa_d   = a;
            opb_d   = b;
            cnt_d   = 5'(MULT_CYCLES - 1);
            state_d = ST_MUL;
          end else begin
`ifdef MDU_DIV_EN
            opa_d   = a_mag;
            opb_d   = b_mag;
            rem_d   = 32'd0;
            qneg_d  = ~op[0] & (a[31] ^ b[31]);
            rneg_d  = ~op[0] & a[31];
            dz_d    = (b == 32'd0);
            cnt_d   = 5'd31;
            state_d = (b == 32'd0) ? ST_FIX : ST_DIV;
`else
            state_d = ST_FIX;
`endif
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == 5'd0) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
`ifdef MDU_DIV_EN
      ST_DIV: begin
        // diff[32] set means the trial subtraction went negative: restore.
        rem_d = diff[32] ? shifted[31:0] : diff[31:0];
        opa_d = {opa_q[30:0], ~diff[32]};
        if (cnt_q == 5'd0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_FIX: begin
        if (!dz_q) begin
          lo_d = qneg_q ? (~opa_q + 32'd1) : opa_q;
          hi_d = rneg_q ? (~rem_q + 32'd1) : rem_q;
        end
        state_d = ST_IDLE;
      end
`else
      ST_FIX: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MDU_DIV_EN
      rem_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_DIV_EN
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign stall_req = use_hilo & (busy | start);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized self-checking bench for mdu_ctrl. HI/LO expectations
// come from plain 64-bit arithmetic on the issued operands; busy lengths come
// from the documented cycle counts.

module tb_mdu_ctrl;

  localparam int MC = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [1:0]  hilo_we;
  logic [31:0] wd;
  logic        use_hilo;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(MC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .hilo_we   (hilo_we),
    .wd        (wd),
    .use_hilo  (use_hilo),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: update m_hi/m_lo for one operation and return its busy length.
  task automatic model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int len);
    longint sx, sy, q, r;
    logic [63:0] p;
    if (!o[1]) begin
      if (o[0]) p = {32'd0, x} * {32'd0, y};
      else begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = 64'(sx * sy);
      end
      m_hi = p[63:32];
      m_lo = p[31:0];
      len  = MC;
    end else begin
`ifdef MDU_DIV_EN
      if (y == 32'd0) begin
        len = 1;
      end else begin
        if (o[0]) begin
          sx = longint'({32'd0, x});
          sy = longint'({32'd0, y});
        end else begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
        end
        q    = sx / sy;
        r    = sx % sy;
        m_lo = q[31:0];
        m_hi = r[31:0];
        len  = 33;
      end
`else
      len = 1;
`endif
    end
  endtask

  task automatic write_hilo(input logic [1:0] we, input logic [31:0] val);
    @(negedge clk);
    hilo_we = we;
    wd      = val;
    if (we[1]) m_hi = val;
    if (we[0]) m_lo = val;
    @(posedge clk); #1;
    hilo_we = 2'b00;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
    chk("mt_busy", busy, 0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic uh, input logic [1:0] we, input logic [31:0] wv,
                        input bit extra);
    int len, n;
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    use_hilo = uh;
    hilo_we  = we;
    wd       = wv;
    if (we[1]) m_hi = wv;
    if (we[0]) m_lo = wv;
    model_op(o, x, y, len);
    #1;
    chk("stall_start", stall_req, uh);
    chk("busy_start", busy, 0);
    @(posedge clk); #1;
    start   = 1'b0;
    hilo_we = 2'b00;
    a       = $urandom;
    b       = $urandom;
    op      = 2'($urandom_range(0, 3));
    n       = 0;
    while (busy && n < 200) begin
      chk("stall_busy", stall_req, uh);
      if (extra && n == 1) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk("busy_len", n, len);
    chk("res_hi", hi, m_hi);
    chk("res_lo", lo, m_lo);
    chk("stall_idle", stall_req, 0);
    use_hilo = 1'b0;
  endtask

  initial begin
    logic [1:0]  ro, rwe;
    logic [31:0] ra, rb;
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    a        = 32'd0;
    b        = 32'd0;
    hilo_we  = 2'b00;
    wd       = 32'd0;
    use_hilo = 1'b1;
    #12;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_req, 0);
    use_hilo = 1'b0;

    // Abort a mult with reset in its second busy cycle.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFE; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy1", busy, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (MC + 2) @(posedge clk);
    #1;
    chk("abort_hi2", hi, 0);
    chk("abort_lo2", lo, 0);

    // Directed cases.
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1, 2'b00, 32'd0, 1'b0);
    chk("mult_hi_k", hi, 32'hFFFF_FFFF);
    chk("mult_lo_k", lo, 32'hFFFF_FFFA);
    run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, 2'b00, 32'd0, 1'b0);
    chk("multu_hi_k", hi, 32'h0000_0002);
    chk("multu_lo_k", lo, 32'hFFFF_FFFA);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 2'b00, 32'd0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 2'b00, 32'd0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2'b00, 32'd0, 1'b0);
    write_hilo(2'b01, 32'h0000_1234);
    run_op(2'b10, 32'd5, 32'd0, 1'b1, 2'b00, 32'd0, 1'b0);
    chk("dz_lo_k", lo, 32'h0000_1234);
    run_op(2'b00, 32'd7, 32'd9, 1'b1, 2'b00, 32'd0, 1'b1);
    write_hilo(2'b10, 32'hA5A5_A5A5);
    run_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 2'b11, 32'h5555_0000, 1'b0);
    run_op(2'b11, 32'd9, 32'd0, 1'b0, 2'b01, 32'h0BAD_F00D, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 48; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      rwe = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 4) == 0) write_hilo(2'($urandom_range(1, 3)), $urandom);
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)), rwe, $urandom,
             ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
